// File: rtl/sensor_pkg.sv
//------------------------------------------------------------------------------
// Module   : sensor_pkg
// Purpose  : Shared defaults and width helper for the sensor conditioner slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sensor_pkg;

  localparam int c_DEF_DEBOUNCE_CYCLES = 4;
  localparam int c_DEF_TEMP_W          = 8;
  localparam int c_DEF_AVG_LOG2        = 2;
  localparam int c_DEF_TEMP_HI         = 31;
  localparam int c_DEF_TEMP_LO         = 29;
  localparam int c_DEF_STUCK_TIMEOUT   = 1000;

  // Summing 2**avg_log2 samples needs avg_log2 extra bits of headroom.
  function automatic int acc_width(input int temp_w, input int avg_log2);
    return temp_w + avg_log2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_debounce.sv
//------------------------------------------------------------------------------
// Module   : sensor_debounce
// Purpose  : 2-FF synchroniser followed by a consecutive-disagreement debouncer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [7:0] c_LAST = 8'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
      $error("sensor_debounce: DEBOUNCE_CYCLES must be within 1..255");
    end
  endgenerate

  logic       r_meta;
  logic       r_sync;
  logic       r_level;
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_level) begin
        r_cnt <= 8'd0;
      end else if (r_cnt == c_LAST) begin
        // The count would reach DEBOUNCE_CYCLES on this edge: accept the new level.
        r_level <= ~r_level;
        r_cnt   <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/sensor_conditioner.sv
//------------------------------------------------------------------------------
// Module   : sensor_conditioner
// Purpose  : Debounce, override toggle, temperature averaging and hysteresis.
//            Optional stuck-sensor watchdog enabled by SENSOR_STUCK_DETECT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
  parameter int TEMP_W          = c_DEF_TEMP_W,
  parameter int AVG_LOG2        = c_DEF_AVG_LOG2,
  parameter int TEMP_HI         = c_DEF_TEMP_HI,
  parameter int TEMP_LO         = c_DEF_TEMP_LO,
  parameter int STUCK_TIMEOUT   = c_DEF_STUCK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              motion_raw,
  input  logic              light_raw,
  input  logic              override_btn,
  input  logic [TEMP_W-1:0] temp_raw,
  input  logic              temp_valid,
  output logic              motion_sensor,
  output logic              light_sensor,
  output logic              manual_override,
  output logic [TEMP_W-1:0] temp_sensor,
  output logic              temp_update,
  output logic              temp_hot,
  output logic              temp_fault
);

  localparam int                  c_ACC_W    = acc_width(TEMP_W, AVG_LOG2);
  localparam int                  c_CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TEMP_W-1:0]   c_HI       = TEMP_W'(TEMP_HI);
  localparam logic [TEMP_W-1:0]   c_LO       = TEMP_W'(TEMP_LO);

  generate
    if (TEMP_LO >= TEMP_HI) begin : g_bad_thresholds
      $error("sensor_conditioner: TEMP_LO must be below TEMP_HI");
    end
    if (STUCK_TIMEOUT < 1) begin : g_bad_timeout
      $error("sensor_conditioner: STUCK_TIMEOUT must be at least 1");
    end
  endgenerate

  logic w_motion;
  logic w_light;
  logic w_btn;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_motion_db (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (motion_raw),
    .o_level (w_motion)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_light_db (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (light_raw),
    .o_level (w_light)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (override_btn),
    .o_level (w_btn)
  );

  logic r_btn_prev;
  logic r_override;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_prev <= 1'b0;
      r_override <= 1'b0;
    end else begin
      r_btn_prev <= w_btn;
      if (w_btn && !r_btn_prev) begin
        r_override <= ~r_override;
      end
    end
  end

  logic [c_ACC_W-1:0] r_acc;
  logic [c_ACC_W-1:0] w_sum;
  logic [c_CNT_W-1:0] r_cnt;
  logic [TEMP_W-1:0]  r_temp;
  logic               r_update;

  assign w_sum = r_acc + c_ACC_W'(temp_raw);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_temp   <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (temp_valid) begin
        if (r_cnt == c_CNT_LAST) begin
          r_temp   <= TEMP_W'(w_sum >> AVG_LOG2);
          r_update <= 1'b1;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  logic w_wd_trip;
  logic w_fault;

`ifdef SENSOR_STUCK_DETECT_EN
  localparam int                 c_WD_W   = $clog2(STUCK_TIMEOUT + 1);
  localparam logic [c_WD_W-1:0]  c_WD_MAX = c_WD_W'(STUCK_TIMEOUT);
  localparam logic [c_WD_W-1:0]  c_WD_PRE = c_WD_W'(STUCK_TIMEOUT - 1);

  logic [c_WD_W-1:0] r_wd;
  logic              r_fault;

  assign w_wd_trip = !temp_valid && (r_wd == c_WD_PRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd    <= '0;
      r_fault <= 1'b0;
    end else if (temp_valid) begin
      r_wd    <= '0;
      r_fault <= 1'b0;
    end else begin
      if (r_wd != c_WD_MAX) begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_wd_trip) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign w_fault = r_fault;
`else
  assign w_wd_trip = 1'b0;
  assign w_fault   = 1'b0;
`endif

  logic r_hot;

  // A watchdog trip forces the fan on; hysteresis resumes from 1 on the next update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hot <= 1'b0;
    end else if (w_wd_trip) begin
      r_hot <= 1'b1;
    end else if (r_update) begin
      if (r_temp >= c_HI) begin
        r_hot <= 1'b1;
      end else if (r_temp <= c_LO) begin
        r_hot <= 1'b0;
      end
    end
  end

  assign motion_sensor   = w_motion;
  assign light_sensor    = w_light;
  assign manual_override = r_override;
  assign temp_sensor     = r_temp;
  assign temp_update     = r_update;
  assign temp_hot        = r_hot;
  assign temp_fault      = w_fault;

endmodule

`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
//------------------------------------------------------------------------------
// Module   : tb_sensor_conditioner
// Purpose  : Self-checking bench for sensor_conditioner against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sensor_conditioner;

  localparam int c_DEB = 4;
  localparam int c_TW  = 8;
  localparam int c_AL  = 2;
  localparam int c_NS  = 4;
  localparam int c_HI  = 31;
  localparam int c_LO  = 29;
`ifdef SENSOR_STUCK_DETECT_EN
  localparam int c_ST      = 50;
  localparam bit c_FAULT_E = 1'b1;
`else
  localparam int c_ST      = 1000;
  localparam bit c_FAULT_E = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            motion_raw = 1'b0;
  logic            light_raw = 1'b0;
  logic            override_btn = 1'b0;
  logic [c_TW-1:0] temp_raw = '0;
  logic            temp_valid = 1'b0;
  logic            motion_sensor;
  logic            light_sensor;
  logic            manual_override;
  logic [c_TW-1:0] temp_sensor;
  logic            temp_update;
  logic            temp_hot;
  logic            temp_fault;

  always #5 clk = ~clk;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES (c_DEB),
    .TEMP_W          (c_TW),
    .AVG_LOG2        (c_AL),
    .TEMP_HI         (c_HI),
    .TEMP_LO         (c_LO),
    .STUCK_TIMEOUT   (c_ST)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .motion_raw      (motion_raw),
    .light_raw       (light_raw),
    .override_btn    (override_btn),
    .temp_raw        (temp_raw),
    .temp_valid      (temp_valid),
    .motion_sensor   (motion_sensor),
    .light_sensor    (light_sensor),
    .manual_override (manual_override),
    .temp_sensor     (temp_sensor),
    .temp_update     (temp_update),
    .temp_hot        (temp_hot),
    .temp_fault      (temp_fault)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: raw levels are seen by the debouncer two edges late,
  // and a debounced output flips once the last c_DEB seen levels all disagree with it.
  bit  p0 [3];
  bit  p1 [3];
  bit  win [3][c_DEB];
  bit  m_db [3];
  bit  m_btn_prev;
  bit  m_ovr;
  int  q [$];
  int  m_temp;
  bit  m_upd;
  bit  m_hot;
  bit  m_fault;
  int  m_idle;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      p0[c] = 1'b0;
      p1[c] = 1'b0;
      m_db[c] = 1'b0;
      for (int k = 0; k < c_DEB; k++) win[c][k] = 1'b0;
    end
    m_btn_prev = 1'b0;
    m_ovr   = 1'b0;
    q.delete();
    m_temp  = 0;
    m_upd   = 1'b0;
    m_hot   = 1'b0;
    m_fault = 1'b0;
    m_idle  = 0;
  endtask

  task automatic model_step();
    bit raw [3];
    bit seen;
    bit all_diff;
    bit nh;
    bit trip;
    int sum;
    raw[0] = motion_raw;
    raw[1] = light_raw;
    raw[2] = override_btn;
    if (m_db[2] && !m_btn_prev) m_ovr = ~m_ovr;
    m_btn_prev = m_db[2];
    for (int c = 0; c < 3; c++) begin
      seen  = p1[c];
      p1[c] = p0[c];
      p0[c] = raw[c];
      for (int k = c_DEB - 1; k > 0; k--) win[c][k] = win[c][k-1];
      win[c][0] = seen;
      all_diff = 1'b1;
      for (int k = 0; k < c_DEB; k++) if (win[c][k] == m_db[c]) all_diff = 1'b0;
      if (all_diff) m_db[c] = ~m_db[c];
    end
    nh = m_hot;
    if (m_upd) begin
      if (m_temp >= c_HI) nh = 1'b1;
      else if (m_temp <= c_LO) nh = 1'b0;
    end
    m_upd = 1'b0;
    if (temp_valid) begin
      q.push_back(int'(temp_raw));
      if (q.size() == c_NS) begin
        sum = 0;
        foreach (q[i]) sum += q[i];
        m_temp = sum / c_NS;
        m_upd  = 1'b1;
        q.delete();
      end
    end
    trip = 1'b0;
`ifdef SENSOR_STUCK_DETECT_EN
    if (temp_valid) begin
      m_idle  = 0;
      m_fault = 1'b0;
    end else if (m_idle < c_ST) begin
      m_idle++;
      if (m_idle == c_ST) begin
        m_fault = 1'b1;
        trip    = 1'b1;
      end
    end
`endif
    if (trip) nh = 1'b1;
    m_hot = nh;
  endtask

  always @(posedge clk) if (rst) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      check("motion", motion_sensor, m_db[0]);
      check("light", light_sensor, m_db[1]);
      check("override", manual_override, m_ovr);
      check("temp", temp_sensor, m_temp);
      check("update", temp_update, m_upd);
      check("hot", temp_hot, m_hot);
      check("fault", temp_fault, m_fault);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    temp_valid = 1'b1;
    temp_raw   = c_TW'(v);
    tick();
    temp_valid = 1'b0;
  endtask

  task automatic feed4(input int a, input int b, input int c, input int d);
    feed(a);
    feed(b);
    feed(c);
    feed(d);
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_outs", {motion_sensor, light_sensor, manual_override, temp_sensor,
                         temp_update, temp_hot, temp_fault}, 0);
    rst = 1'b1;
    repeat (20) tick();
    check("idle_outs", {motion_sensor, light_sensor, manual_override, temp_sensor,
                        temp_update, temp_hot, temp_fault}, 0);

    // Debounce latency and glitch rejection.
    motion_raw = 1'b1;
    repeat (5) tick();
    check("motion_pre", motion_sensor, 0);
    tick();
    check("motion_lat", motion_sensor, 1);
    motion_raw = 1'b0;
    repeat (10) tick();
    check("motion_fall", motion_sensor, 0);
    motion_raw = 1'b1;
    repeat (3) tick();
    motion_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("glitch", motion_sensor, 0);
    end

    // Override toggle.
    override_btn = 1'b1; repeat (10) tick();
    override_btn = 1'b0; repeat (10) tick();
    check("ovr_on", manual_override, 1);
    override_btn = 1'b1; repeat (10) tick();
    override_btn = 1'b0; repeat (10) tick();
    check("ovr_off", manual_override, 0);
    override_btn = 1'b1; repeat (50) tick();
    check("ovr_hold", manual_override, 1);
    override_btn = 1'b0; repeat (10) tick();
    check("ovr_release", manual_override, 1);

    // Averaging and hysteresis.
    feed4(28, 30, 32, 34);
    check("avg31", temp_sensor, 31);
    check("avg31_upd", temp_update, 1);
    tick();
    check("hot_set", temp_hot, 1);
    check("upd_once", temp_update, 0);
    feed4(30, 30, 30, 29);
    check("avg29", temp_sensor, 29);
    tick();
    check("hot_clr", temp_hot, 0);
    feed4(30, 30, 30, 30);
    check("avg30", temp_sensor, 30);
    tick();
    check("hot_hold", temp_hot, 0);

    // Watchdog window (only trips with the stuck detector built in).
    repeat (48) tick();
    check("fault_pre", temp_fault, 0);
    tick();
    check("fault_set", temp_fault, c_FAULT_E);
    check("fault_hot", temp_hot, c_FAULT_E);
    feed(30);
    check("fault_clr", temp_fault, 0);

    // Reset in the middle of an average discards the partial sum.
    feed(50);
    feed(50);
    rst = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
    feed4(40, 40, 40, 40);
    check("avg_after_rst", temp_sensor, 40);
    tick();
    check("hot_after_rst", temp_hot, 1);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) motion_raw   = ~motion_raw;
      if ($urandom_range(0, 5) == 0) light_raw    = ~light_raw;
      if ($urandom_range(0, 5) == 0) override_btn = ~override_btn;
      temp_valid = (i >= 2000 && i < 2100) ? 1'b0 : ($urandom_range(0, 2) == 0);
      temp_raw   = c_TW'($urandom_range(20, 40));
      if (i == 1500) begin
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
      end
      tick();
    end
    temp_valid = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Front-end stage placed directly upstream of smart_home_automation.
- Turns raw, asynchronous and noisy sensor/button inputs into clean, clk-synchronous signals: motion_sensor, light_sensor, manual_override and temp_sensor.
- Functions: per-input synchronise + debounce, pushbutton-to-toggle latch for override, N-sample averaging of ADC temperature, hysteresis hot flag.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive disagreeing cycles required before a debounced output flips (legal range 1..255).
- TEMP_W, 8, temperature sample width.
- AVG_LOG2, 2, log2 of the number of samples averaged (N = 4).
- TEMP_HI, 31, temp_hot sets when the averaged value is >= TEMP_HI.
- TEMP_LO, 29, temp_hot clears when the averaged value is <= TEMP_LO. TEMP_LO < TEMP_HI is required; elaboration error otherwise.
- STUCK_TIMEOUT, 1000, cycles without temp_valid before a fault is raised (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- motion_raw  in  1  PIR input, asynchronous
- light_raw  in  1  ambient comparator input, asynchronous (1 = bright)
- override_btn  in  1  momentary pushbutton, asynchronous
- temp_raw  in  TEMP_W  ADC sample, clk-synchronous
- temp_valid  in  1  one-cycle strobe qualifying temp_raw
- motion_sensor  out  1  debounced motion
- light_sensor  out  1  debounced light
- manual_override  out  1  toggle latch
- temp_sensor  out  TEMP_W  averaged temperature
- temp_update  out  1  one-cycle pulse when temp_sensor is loaded
- temp_hot  out  1  hysteresis over-temperature flag
- temp_fault  out  1  stuck-sensor flag; constant 0 without the optional feature

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0.
  - Synchronisers, debounce counters, accumulator and sample counter are cleared.
  - A partial average in progress at reset is discarded.
- Synchroniser: each of motion_raw, light_raw and override_btn passes through a 2-FF synchroniser.
- Debounce:
  - Per-input counter increments while the synchronised value differs from the output.
  - The counter clears to 0 on any cycle where they agree.
  - The output flips on the edge at which the counter would reach DEBOUNCE_CYCLES; the counter clears on that edge.
  - Latency: a raw level stable from before edge 0 is visible on the output after edge DEBOUNCE_CYCLES+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never propagates.
- Override toggle:
  - A rising edge of debounced override_btn inverts manual_override on the next edge.
  - Holding the button does not re-toggle. Falling edges are ignored.
- Averaging:
  - Accumulator width is TEMP_W+AVG_LOG2; it cannot overflow.
  - Sample counter counts 0..N-1.
  - On a temp_valid edge with count < N-1: acc += temp_raw, count++.
  - On the temp_valid edge with count == N-1:
    - temp_sensor <= (acc + temp_raw) >> AVG_LOG2 (truncating).
    - temp_update <= 1 for exactly one cycle.
    - acc <= 0, count <= 0.
  - temp_raw is ignored when temp_valid=0.
  - Back-to-back temp_valid is legal: a full average every N cycles, giving an update pulse every N cycles.
- Hysteresis:
  - Evaluated on the cycle temp_update=1, using the new temp_sensor; the result is registered one edge later.
  - If value >= TEMP_HI then temp_hot = 1.
  - Else if value <= TEMP_LO then temp_hot = 0.
  - Otherwise temp_hot holds.
- Simultaneous debounce flips on different inputs are independent; there are no cross-channel interactions.

Optional Feature:
- Macro SENSOR_STUCK_DETECT_EN.
- Defined:
  - A watchdog counter increments every cycle and clears on temp_valid.
  - On reaching STUCK_TIMEOUT: temp_fault <= 1 and temp_hot is forced to 1 (fail-safe fan on). The counter saturates.
  - temp_fault clears on the edge after the next temp_valid.
  - temp_hot then resumes hysteresis from its forced value of 1 at the next temp_update.
- Undefined: no watchdog logic; temp_fault is tied to 0.

Decomposition:
- Package sensor_pkg holds:
  - default constants for DEBOUNCE_CYCLES, TEMP_W, TEMP_HI, TEMP_LO, AVG_LOG2, STUCK_TIMEOUT;
  - the function computing accumulator width.
- Sub-module sensor_debounce (2-FF synchroniser + counter + output register, parameter DEBOUNCE_CYCLES), instantiated three times.
- Averaging, hysteresis, toggle and watchdog logic stay in the top level.

Test Plan (DEBOUNCE_CYCLES=4, AVG_LOG2=2):
- Reset then hold rst=1 with all inputs 0 -> all outputs stay 0 for 20 cycles.
- motion_raw 0->1 held -> motion_sensor=1 after edge 5 relative to the first sampling edge. A separate 3-cycle pulse -> motion_sensor stays 0.
- override_btn pressed 10 cycles, released, pressed 10 cycles again -> manual_override goes 1, then 0. The first press held 50 cycles toggles only once.
- temp_valid samples 28,30,32,34 -> temp_sensor=31 with a single temp_update pulse, and temp_hot=1 one cycle later.
- Then 30,30,30,29 -> temp_sensor=29, temp_hot=0. Then 30,30,30,30 -> temp_sensor=30, temp_hot holds at 0.
- Assert rst after 2 of 4 samples, then feed 40,40,40,40 -> temp_sensor=40 (partial sum discarded).
- With SENSOR_STUCK_DETECT_EN and STUCK_TIMEOUT=50: no temp_valid for 50 cycles -> temp_fault=1 and temp_hot=1. Then one temp_valid -> temp_fault=0.
